// File: rtl/if_id_pipe_reg_if.sv
// Bundle between fetch, decode and the IF/ID pipeline register: fetched data and
// hazard inputs in, registered IF/ID contents, fetch/bubble controls and debug counters out.
interface if_id_pipe_reg_if #(
  parameter int ADDR_WIDTH  = 10,
  parameter int INSTR_WIDTH = 32,
  parameter int CNT_WIDTH   = 16
);
  logic [ADDR_WIDTH-1:0]  pc_plus4;
  logic [INSTR_WIDTH-1:0] instr;
  logic                   branch_taken;
  logic                   jump;
  logic                   id_ex_mem_read;
  logic [4:0]             id_ex_rt;

  logic [ADDR_WIDTH-1:0]  if_id_pc_plus4;
  logic [INSTR_WIDTH-1:0] if_id_instr;
  logic                   if_id_valid;
  logic                   pc_write_en;
  logic                   id_ex_bubble;
  logic [CNT_WIDTH-1:0]   stall_count;
  logic [CNT_WIDTH-1:0]   flush_count;

  modport master (
    output pc_plus4, instr, branch_taken, jump, id_ex_mem_read, id_ex_rt,
    input  if_id_pc_plus4, if_id_instr, if_id_valid, pc_write_en, id_ex_bubble,
           stall_count, flush_count
  );

  modport slave (
    input  pc_plus4, instr, branch_taken, jump, id_ex_mem_read, id_ex_rt,
    output if_id_pc_plus4, if_id_instr, if_id_valid, pc_write_en, id_ex_bubble,
           stall_count, flush_count
  );
endinterface

// File: rtl/if_id_pipe_reg.sv
// IF/ID pipeline register with load-use stall detection, branch/jump flush and
// saturating stall/flush event counters for debug.
module if_id_pipe_reg #(
  parameter int                     ADDR_WIDTH  = 10,
  parameter int                     INSTR_WIDTH = 32,
  parameter int                     CNT_WIDTH   = 16,
  parameter logic [INSTR_WIDTH-1:0] NOP_INSTR   = '0
) (
  input  logic            clk,
  input  logic            reset,
  if_id_pipe_reg_if.slave bus
);

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    STALL   = 2'd1,
    FLUSHED = 2'd2
  } state_e;

  localparam logic [CNT_WIDTH-1:0] CntOne = {{(CNT_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [CNT_WIDTH-1:0] CntMax = '1;

  state_e                 state_q, state_d;
  logic [ADDR_WIDTH-1:0]  pc_q, pc_d;
  logic [INSTR_WIDTH-1:0] instr_q, instr_d;
  logic                   valid_q, valid_d;
  logic [CNT_WIDTH-1:0]   stall_cnt_q, stall_cnt_d;
  logic [CNT_WIDTH-1:0]   flush_cnt_q, flush_cnt_d;

  logic [4:0] rs;
  logic [4:0] rt;
  logic       hazard;
  logic       flush;

  assign rs    = instr_q[25:21];
  assign rt    = instr_q[20:16];
  assign flush = bus.branch_taken | bus.jump;

  // A flushed slot holds no real instruction, so it can never be the consumer of a load.
  assign hazard = valid_q & (state_q != FLUSHED) & bus.id_ex_mem_read &
                  (bus.id_ex_rt != 5'd0) &
                  ((bus.id_ex_rt == rs) | (bus.id_ex_rt == rt));

  always_comb begin
    state_d     = RUN;
    pc_d        = bus.pc_plus4;
    instr_d     = bus.instr;
    valid_d     = 1'b1;
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (flush) begin
      state_d = FLUSHED;
      instr_d = NOP_INSTR;
      valid_d = 1'b0;
      if (flush_cnt_q != CntMax) flush_cnt_d = flush_cnt_q + CntOne;
    end else if (hazard) begin
      state_d = STALL;
      pc_d    = pc_q;
      instr_d = instr_q;
      valid_d = valid_q;
      if (stall_cnt_q != CntMax) stall_cnt_d = stall_cnt_q + CntOne;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= RUN;
      pc_q        <= '0;
      instr_q     <= NOP_INSTR;
      valid_q     <= 1'b0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      instr_q     <= instr_d;
      valid_q     <= valid_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  // Fetch must keep running on a flush so the redirect target gets fetched.
  assign bus.pc_write_en    = ~hazard | flush;
  assign bus.id_ex_bubble   = hazard & ~flush;
  assign bus.if_id_pc_plus4 = pc_q;
  assign bus.if_id_instr    = instr_q;
  assign bus.if_id_valid    = valid_q;
  assign bus.stall_count    = stall_cnt_q;
  assign bus.flush_count    = flush_cnt_q;

endmodule

// File: tb/tb_if_id_pipe_reg.sv
// Self-checking bench for if_id_pipe_reg: a per-cycle behavioural model compared on
// every falling edge, plus directed vectors with hand-computed literal expectations.
module tb_if_id_pipe_reg;

  localparam int AW     = 10;
  localparam int IW     = 32;
  localparam int CW     = 4;
  localparam int CntMax = (1 << CW) - 1;

  logic clk;
  logic reset;

  int checkCount = 0;
  int failCount  = 0;

  if_id_pipe_reg_if #(.ADDR_WIDTH(AW), .INSTR_WIDTH(IW), .CNT_WIDTH(CW)) bus ();

  if_id_pipe_reg #(
    .ADDR_WIDTH (AW),
    .INSTR_WIDTH(IW),
    .CNT_WIDTH  (CW),
    .NOP_INSTR  (32'h0000_0000)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: what IF/ID must hold, derived from the pipeline rules.
  logic [AW-1:0] mPc;
  logic [IW-1:0] mInstr;
  bit            mValid;
  int            mStalls;
  int            mFlushes;

  function automatic bit modelHazard();
    int srcA;
    int srcB;
    srcA = int'((mInstr >> 21) & 32'd31);
    srcB = int'((mInstr >> 16) & 32'd31);
    return mValid && bus.id_ex_mem_read && (bus.id_ex_rt != 0) &&
           ((int'(bus.id_ex_rt) == srcA) || (int'(bus.id_ex_rt) == srcB));
  endfunction

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      mPc = '0; mInstr = '0; mValid = 0; mStalls = 0; mFlushes = 0;
    end else if (bus.branch_taken || bus.jump) begin
      mPc = bus.pc_plus4; mInstr = '0; mValid = 0;
      mFlushes = (mFlushes < CntMax) ? mFlushes + 1 : CntMax;
    end else if (modelHazard()) begin
      mStalls = (mStalls < CntMax) ? mStalls + 1 : CntMax;
    end else begin
      mPc = bus.pc_plus4; mInstr = bus.instr; mValid = 1;
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checkCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %h, expected %h at %0t", name, actual, expected, $time);
    end
  endtask

  always @(negedge clk) begin
    bit hz;
    bit fl;
    hz = modelHazard();
    fl = bus.branch_taken || bus.jump;
    checkOutput("model.pc",     32'(bus.if_id_pc_plus4), 32'(mPc));
    checkOutput("model.instr",  bus.if_id_instr,         mInstr);
    checkOutput("model.valid",  32'(bus.if_id_valid),    32'(mValid));
    checkOutput("model.pcwe",   32'(bus.pc_write_en),    32'(!hz || fl));
    checkOutput("model.bubble", 32'(bus.id_ex_bubble),   32'(hz && !fl));
    checkOutput("model.stalls", 32'(bus.stall_count),    32'(mStalls));
    checkOutput("model.flushes",32'(bus.flush_count),    32'(mFlushes));
  end

  task automatic applyStimulus(input logic [AW-1:0] pc, input logic [IW-1:0] ins,
                               input bit br, input bit jmp, input bit mr,
                               input logic [4:0] rt);
    bus.pc_plus4       = pc;
    bus.instr          = ins;
    bus.branch_taken   = br;
    bus.jump           = jmp;
    bus.id_ex_mem_read = mr;
    bus.id_ex_rt       = rt;
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b0;
    applyStimulus(10'h000, 32'h0, 0, 0, 0, 5'd0);
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst.instr",  bus.if_id_instr,         32'h0);
    checkOutput("rst.valid",  32'(bus.if_id_valid),    32'h0);
    checkOutput("rst.stalls", 32'(bus.stall_count),    32'h0);
    checkOutput("rst.flush",  32'(bus.flush_count),    32'h0);
    checkOutput("rst.pcwe",   32'(bus.pc_write_en),    32'h1);

    reset = 1'b1;
    applyStimulus(10'h004, 32'h012A4020, 0, 0, 0, 5'd0);
    tick();
    checkOutput("load.pc",    32'(bus.if_id_pc_plus4), 32'h004);
    checkOutput("load.instr", bus.if_id_instr,         32'h012A4020);
    checkOutput("load.valid", 32'(bus.if_id_valid),    32'h1);

    // Load-use on rs=8.
    applyStimulus(10'h008, 32'h01095020, 0, 0, 0, 5'd0);
    tick();
    applyStimulus(10'h00C, 32'h0150_5820, 0, 0, 1, 5'd8);
    #1;
    checkOutput("lu.pcwe",    32'(bus.pc_write_en),    32'h0);
    checkOutput("lu.bubble",  32'(bus.id_ex_bubble),   32'h1);
    tick();
    checkOutput("lu.holdI",   bus.if_id_instr,         32'h01095020);
    checkOutput("lu.holdPc",  32'(bus.if_id_pc_plus4), 32'h008);
    applyStimulus(10'h00C, 32'h0150_5820, 0, 0, 0, 5'd8);
    tick();
    checkOutput("lu.resume",  bus.if_id_instr,         32'h0150_5820);
    checkOutput("lu.stalls",  32'(bus.stall_count),    32'h1);

    // Stall qualification: $zero, rt match, no load.
    applyStimulus(10'h010, 32'h01095020, 0, 0, 0, 5'd0);
    tick();
    applyStimulus(10'h014, 32'h0, 0, 0, 1, 5'd0);
    #1;
    checkOutput("ns.zero",    32'(bus.pc_write_en),    32'h1);
    applyStimulus(10'h014, 32'h0, 0, 0, 1, 5'd9);
    #1;
    checkOutput("ns.rtMatch", 32'(bus.pc_write_en),    32'h0);
    applyStimulus(10'h014, 32'h0, 0, 0, 0, 5'd9);
    #1;
    checkOutput("ns.noLoad",  32'(bus.pc_write_en),    32'h1);

    // Flush wins over an active load-use hazard.
    applyStimulus(10'h018, 32'h2222_2222, 1, 0, 1, 5'd8);
    #1;
    checkOutput("fl.pcwe",    32'(bus.pc_write_en),    32'h1);
    checkOutput("fl.bubble",  32'(bus.id_ex_bubble),   32'h0);
    tick();
    checkOutput("fl.instr",   bus.if_id_instr,         32'h0);
    checkOutput("fl.valid",   32'(bus.if_id_valid),    32'h0);
    checkOutput("fl.pc",      32'(bus.if_id_pc_plus4), 32'h018);
    checkOutput("fl.count",   32'(bus.flush_count),    32'h1);
    checkOutput("fl.stalls",  32'(bus.stall_count),    32'h1);
    applyStimulus(10'h01C, 32'h3333_3333, 1, 1, 0, 5'd0);
    tick();
    checkOutput("fl.both",    32'(bus.flush_count),    32'h2);

    // Enter STALL, then reset asynchronously between edges.
    applyStimulus(10'h020, 32'h01095020, 0, 0, 0, 5'd0);
    tick();
    applyStimulus(10'h024, 32'h4444_4444, 0, 0, 1, 5'd9);
    tick();
    checkOutput("ar.stalled", 32'(bus.stall_count),    32'h2);
    #1;
    reset = 1'b0;
    #1;
    checkOutput("ar.instr",   bus.if_id_instr,         32'h0);
    checkOutput("ar.valid",   32'(bus.if_id_valid),    32'h0);
    checkOutput("ar.pc",      32'(bus.if_id_pc_plus4), 32'h0);
    checkOutput("ar.stalls",  32'(bus.stall_count),    32'h0);
    checkOutput("ar.pcwe",    32'(bus.pc_write_en),    32'h1);
    #1;
    reset = 1'b1;
    tick();
    checkOutput("ar.capture", bus.if_id_instr,         32'h4444_4444);
    checkOutput("ar.capPc",   32'(bus.if_id_pc_plus4), 32'h024);

    // Counter saturation.
    applyStimulus(10'h030, 32'h5555_5555, 1, 0, 0, 5'd0);
    repeat (20) tick();
    checkOutput("sat.flush",  32'(bus.flush_count),    32'hF);
    checkOutput("sat.stalls", 32'(bus.stall_count),    32'h0);

    applyStimulus(10'h034, 32'h0, 0, 0, 0, 5'd0);
    tick();
    @(negedge clk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", checkCount, failCount);
    $finish;
  end

endmodule
